// File: rtl/tx_arb_pkg.sv
// Shared types for the UART transmit arbiter and its round-robin picker.
package tx_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } tx_arb_state_t;

  // Index width for n requesters; never zero so a 1-bit index survives n<=2.
  function automatic int clog2_req(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index strictly after `last`,
// wrapping modulo N. `pick` is meaningless when `any` is low.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int  N  = 2,
  localparam int LW = clog2_req(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] pick,
  output logic          any
);

  int idx;

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    pick = last;
    any  = 1'b0;
    idx  = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (valid[idx]) begin
        pick = LW'(idx);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit pipe between NUM_REQ byte
// producers, with message locking and an optional burst limit.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 2,
  parameter int  WIDTH     = 8,
  parameter int  MAX_BURST = 0,
  localparam int GW        = clog2_req(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_lock,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     pipe_full,
  output logic                     pipe_push,
  output logic [WIDTH-1:0]         pipe_data,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  localparam int            CW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [GW-1:0] LAST_INIT  = GW'(NUM_REQ - 1);

  tx_arb_state_t    state_reg;
  logic [GW-1:0]    grant_reg;
  logic [GW-1:0]    last_reg;
  logic [CW-1:0]    count_reg;
  logic             push_reg;
  logic [WIDTH-1:0] data_reg;
  logic             busy_reg;

  logic [GW-1:0]    pick_idx;
  logic             pick_any;
  logic             gnt_valid;
  logic             gnt_lock;
  logic [WIDTH-1:0] gnt_data;
  logic             serve_ok;
  logic             transfer;
  logic             forced_rel;
  logic             rel_now;

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .valid (req_valid),
    .last  (last_reg),
    .pick  (pick_idx),
    .any   (pick_any)
  );

  assign gnt_valid = req_valid[grant_reg];
  assign gnt_lock  = req_lock[grant_reg];
  assign gnt_data  = req_data[int'(grant_reg)*WIDTH +: WIDTH];

  // Blocking on push_reg spaces accepts two cycles apart, so a pipe_full that
  // lags the previous push by a cycle can never let an overflow push through.
  assign serve_ok   = (state_reg == SERVE) && !pipe_full && !push_reg;
  assign transfer   = serve_ok && gnt_valid;
  assign forced_rel = (MAX_BURST != 0) && transfer && (count_reg == BURST_LAST);
  assign rel_now    = (transfer && !gnt_lock) || (!gnt_valid && !gnt_lock) || forced_rel;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = serve_ok && (grant_reg == GW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= LAST_INIT;
      count_reg <= '0;
      push_reg  <= 1'b0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      push_reg <= transfer;
      if (transfer) begin
        data_reg <= gnt_data;
      end
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant_reg <= pick_idx;
            busy_reg  <= 1'b1;
            count_reg <= '0;
            state_reg <= SERVE;
          end
        end
        SERVE: begin
          if (rel_now) begin
            state_reg <= IDLE;
            last_reg  <= grant_reg;
            busy_reg  <= 1'b0;
          end else if (transfer && (count_reg != BURST_LAST)) begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pipe_push = push_reg;
  assign pipe_data = data_reg;
  assign grant_id  = grant_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: per-cycle comparison against a behavioural
// model plus a literal expected byte stream for every scenario.
module tb_tx_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              pipe_full;
  logic              pipe_push;
  logic [W-1:0]      pipe_data;
  logic              grant_id;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int push_cnt = 0;
  bit chk_en   = 1'b0;

  // Requester sources: byte queues with a per-byte lock flag.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         l0[$];
  bit         l1[$];
  bit         lock_idle1 = 1'b0;
  logic [7:0] exp_stream[$];

  // Behavioural model state.
  bit         m_busy;
  bit         m_push;
  int         m_owner;
  int         m_last;
  int         m_burst;
  logic [7:0] m_data;
  logic [NREQ-1:0] exp_ready;

  tx_arbiter #(
    .NUM_REQ   (NREQ),
    .WIDTH     (W),
    .MAX_BURST (MAXB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .pipe_full (pipe_full),
    .pipe_push (pipe_push),
    .pipe_data (pipe_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_push  = 1'b0;
    m_data  = 8'h00;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_burst = 0;
  endtask

  // One clock edge of the arbiter described by its rules, using the inputs
  // that were present at the edge.
  task automatic model_step();
    int  pick;
    int  idx;
    bit  xfer;
    if (!m_busy) begin
      m_push = 1'b0;
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (pick < 0 && req_valid[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_busy  = 1'b1;
        m_burst = 0;
      end
    end else begin
      xfer   = req_valid[m_owner] && !pipe_full && !m_push;
      m_push = xfer;
      if (xfer) m_data = req_data[m_owner*W +: W];
      if ((xfer && !req_lock[m_owner]) ||
          (!req_valid[m_owner] && !req_lock[m_owner]) ||
          (MAXB != 0 && xfer && m_burst == MAXB - 1)) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (xfer && m_burst < MAXB - 1) begin
        m_burst++;
      end
    end
  endtask

  task automatic drive();
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    if (q0.size() > 0) begin
      req_valid[0]   = 1'b1;
      req_lock[0]    = l0[0];
      req_data[7:0]  = q0[0];
    end
    if (lock_idle1) begin
      req_lock[1] = 1'b1;
    end else if (q1.size() > 0) begin
      req_valid[1]   = 1'b1;
      req_lock[1]    = l1[0];
      req_data[15:8] = q1[0];
    end
  endtask

  task automatic add0(input logic [7:0] b, input bit lk);
    q0.push_back(b);
    l0.push_back(lk);
  endtask

  task automatic add1(input logic [7:0] b, input bit lk);
    q1.push_back(b);
    l1.push_back(lk);
  endtask

  task automatic tick();
    logic [NREQ-1:0] xfer;
    logic [7:0]      d8;
    bit              db;
    @(negedge clk);
    xfer = req_valid & req_ready;
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    #1;
    if (xfer[0] && q0.size() > 0) begin d8 = q0.pop_front(); db = l0.pop_front(); end
    if (xfer[1] && q1.size() > 0) begin d8 = q1.pop_front(); db = l1.pop_front(); end
    drive();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_stream.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain: %0d bytes never pushed within %0d cycles", name, exp_stream.size(), budget);
    end
    repeat (2) tick();
  endtask

  // Per-cycle comparison against the model, plus the literal byte stream.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NREQ; i++)
        exp_ready[i] = m_busy && (m_owner == i) && !pipe_full && !m_push;
      chk("req_ready", int'(req_ready), int'(exp_ready));
      chk("pipe_push", int'(pipe_push), int'(m_push));
      chk("pipe_data", int'(pipe_data), int'(m_data));
      chk("grant_id",  int'(grant_id),  m_owner);
      chk("busy",      int'(busy),      int'(m_busy));
      if (pipe_push) begin
        push_cnt++;
        if (exp_stream.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream: unexpected push of 0x%02h", pipe_data);
        end else begin
          chk("stream", int'(pipe_data), int'(exp_stream.pop_front()));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    pipe_full = 1'b0;
    drive();
    model_reset();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    chk("rst_busy",  int'(busy),      0);
    chk("rst_push",  int'(pipe_push), 0);
    chk("rst_grant", int'(grant_id),  0);
    chk("rst_data",  int'(pipe_data), 0);

    // Reset in the middle of a transfer: pending push and grant are lost.
    add1(8'hA5, 1'b0);
    drive();
    tick();
    chk("t1_grant", int'(grant_id), 1);
    tick();
    chk("t1_push_pending", int'(pipe_push), 1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("t1_rst_push",  int'(pipe_push), 0);
    chk("t1_rst_busy",  int'(busy),      0);
    chk("t1_rst_grant", int'(grant_id),  0);
    tick();
    tick();
    rst = 1'b1;

    // Fairness: two unlocked bytes each alternate 0,1,0,1.
    add0(8'h10, 1'b0); add0(8'h20, 1'b0);
    add1(8'h11, 1'b0); add1(8'h21, 1'b0);
    exp_stream = '{8'h10, 8'h11, 8'h20, 8'h21};
    drive();
    drain("t2", 60);

    // Lock: "OK\n" from requester 1 stays contiguous while requester 0 waits.
    add1(8'h4F, 1'b1); add1(8'h4B, 1'b1); add1(8'h0A, 1'b0);
    drive();
    tick();
    chk("t3_grant", int'(grant_id), 1);
    add0(8'h30, 1'b0);
    exp_stream = '{8'h4F, 8'h4B, 8'h0A, 8'h30};
    drive();
    drain("t3", 60);

    // Backpressure: 20 cycles of pipe_full while granted.
    add0(8'h44, 1'b0);
    exp_stream = '{8'h44};
    drive();
    tick();
    pipe_full = 1'b1;
    base = push_cnt;
    repeat (20) tick();
    chk("t4_no_push", push_cnt - base, 0);
    chk("t4_busy",    int'(busy),      1);
    chk("t4_ready",   int'(req_ready), 0);
    pipe_full = 1'b0;
    drain("t4", 30);
    chk("t4_one_push", push_cnt - base, 1);

    // Burst limit of 4 bytes breaks a long locked message.
    for (int i = 0; i < 10; i++) add0(8'h50 + 8'(i), (i != 9));
    drive();
    tick();
    chk("t5_grant", int'(grant_id), 0);
    add1(8'h61, 1'b0);
    exp_stream = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h61,
                   8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
    drive();
    drain("t5", 120);

    // Locked idle holds the grant; dropping the lock releases it next cycle.
    add1(8'h71, 1'b1);
    exp_stream = '{8'h71, 8'h70};
    drive();
    tick();
    tick();
    lock_idle1 = 1'b1;
    add0(8'h70, 1'b0);
    drive();
    repeat (6) tick();
    chk("t6_hold_busy",    int'(busy),     1);
    chk("t6_hold_grant",   int'(grant_id), 1);
    chk("t6_hold_pending", exp_stream.size(), 1);
    lock_idle1 = 1'b0;
    drive();
    tick();
    chk("t6_release", int'(busy), 0);
    drain("t6", 30);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
